// File: rtl/tc_rd_sched.sv
// Read-request scheduler: shares one tensor read engine among NREQ loaders.
// Define TC_RDSCHED_FIXED_PRIO_EN for fixed lowest-index-first arbitration.
module tc_rd_sched #(
   parameter int NREQ       = 3,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 256
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NREQ-1:0]            req_valid,
   output logic [NREQ-1:0]            req_ready,
   input  logic [NREQ*ADDR_WIDTH-1:0] req_base,
   input  logic [NREQ*6-1:0]          req_burst_num,
   input  logic [NREQ*3-1:0]          req_burst_size,
   output logic                       rd_req_valid,
   input  logic                       rd_req_ready,
   output logic [ADDR_WIDTH-1:0]      rd_base,
   output logic [5:0]                 rd_burst_num,
   output logic [2:0]                 rd_burst_size,
   output logic [2:0]                 rd_sel,
   input  logic                       rd_valid,
   input  logic [DATA_WIDTH-1:0]      rd_data,
   input  logic                       rd_finish,
   input  logic [31:0]                rd_burst_id,
   output logic [NREQ-1:0]            rsp_valid,
   output logic [DATA_WIDTH-1:0]      rsp_data,
   output logic [31:0]                rsp_burst_id,
   output logic [NREQ-1:0]            rsp_done,
   output logic [15:0]                rsp_beat_cnt,
   output logic                       busy,
   output logic                       err
);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DATA,
      ZDONE
   } state_t;

   state_t                state_q;
   logic [2:0]            rr_q;
   logic [2:0]            rr_d;
   logic [2:0]            sel_q;
   logic [ADDR_WIDTH-1:0] base_q;
   logic [5:0]            num_q;
   logic [2:0]            size_q;
   logic [15:0]           cnt_q;
   logic [15:0]           cnt_d;
   logic                  err_q;

   logic                  found;
   logic [2:0]            gnt;
   logic [NREQ-1:0]       hi_vec;
   logic [ADDR_WIDTH-1:0] gnt_base;
   logic [5:0]            gnt_num;
   logic [2:0]            gnt_size;

   // Lowest valid index at or above rr_q wins, else lowest valid overall.
   // With rr_q pinned at 0 this degenerates to fixed priority.
   always_comb begin
      found  = |req_valid;
      gnt    = '0;
      hi_vec = '0;
      for (int i = 0; i < NREQ; i++) begin
         hi_vec[i] = req_valid[i] && (i >= int'(rr_q));
      end
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (req_valid[i]) gnt = 3'(i);
      end
      if (|hi_vec) begin
         for (int i = NREQ - 1; i >= 0; i--) begin
            if (hi_vec[i]) gnt = 3'(i);
         end
      end
   end

   always_comb begin
      gnt_base = '0;
      gnt_num  = '0;
      gnt_size = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt == 3'(i)) begin
            gnt_base = req_base[i*ADDR_WIDTH +: ADDR_WIDTH];
            gnt_num  = req_burst_num[i*6 +: 6];
            gnt_size = req_burst_size[i*3 +: 3];
         end
      end
   end

   always_comb begin
`ifdef TC_RDSCHED_FIXED_PRIO_EN
      rr_d = '0;
`else
      rr_d = (gnt == 3'(NREQ - 1)) ? 3'd0 : gnt + 3'd1;
`endif
   end

   always_comb begin
      cnt_d = cnt_q;
      if (rd_valid && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         rr_q    <= '0;
         sel_q   <= '0;
         base_q  <= '0;
         num_q   <= '0;
         size_q  <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         if ((rd_valid || rd_finish) && state_q != DATA) err_q <= 1'b1;
         unique case (state_q)
            IDLE: begin
               if (found) begin
                  sel_q   <= gnt;
                  base_q  <= gnt_base;
                  num_q   <= gnt_num;
                  size_q  <= gnt_size;
                  rr_q    <= rr_d;
                  state_q <= (gnt_num == 6'd0) ? ZDONE : ISSUE;
               end
            end
            ISSUE: begin
               if (rd_req_ready) begin
                  cnt_q   <= '0;
                  state_q <= DATA;
               end
            end
            DATA: begin
               cnt_q <= cnt_d;
               if (rd_finish) state_q <= IDLE;
            end
            ZDONE: state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   always_comb begin
      req_ready = '0;
      rsp_valid = '0;
      rsp_done  = '0;
      for (int i = 0; i < NREQ; i++) begin
         req_ready[i] = state_q == IDLE && found && gnt == 3'(i);
         rsp_valid[i] = state_q == DATA && rd_valid && sel_q == 3'(i);
         rsp_done[i]  = sel_q == 3'(i) &&
                        ((state_q == DATA && rd_finish) || state_q == ZDONE);
      end
   end

   assign rd_req_valid  = state_q == ISSUE;
   assign rd_base       = base_q;
   assign rd_burst_num  = num_q;
   assign rd_burst_size = size_q;
   assign rd_sel        = sel_q;
   assign rsp_data      = (state_q == DATA) ? rd_data : '0;
   assign rsp_burst_id  = (state_q == DATA) ? rd_burst_id : '0;
   assign rsp_beat_cnt  = cnt_q;
   assign busy          = state_q != IDLE;
   assign err           = err_q;

endmodule

// File: tb/tb_tc_rd_sched.sv
// Randomized bench for tc_rd_sched against a transaction-level reference
// model of arbitration order, steering, beat counts and the error flag.
module tb_tc_rd_sched;

   localparam int NREQ = 3;
   localparam int AW   = 32;
   localparam int DW   = 256;

   logic              clk;
   logic              rst;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ*AW-1:0] req_base;
   logic [NREQ*6-1:0] req_burst_num;
   logic [NREQ*3-1:0] req_burst_size;
   logic              rd_req_valid;
   logic              rd_req_ready;
   logic [AW-1:0]     rd_base;
   logic [5:0]        rd_burst_num;
   logic [2:0]        rd_burst_size;
   logic [2:0]        rd_sel;
   logic              rd_valid;
   logic [DW-1:0]     rd_data;
   logic              rd_finish;
   logic [31:0]       rd_burst_id;
   logic [NREQ-1:0]   rsp_valid;
   logic [DW-1:0]     rsp_data;
   logic [31:0]       rsp_burst_id;
   logic [NREQ-1:0]   rsp_done;
   logic [15:0]       rsp_beat_cnt;
   logic              busy;
   logic              err;

   tc_rd_sched #(.NREQ(NREQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_base(req_base), .req_burst_num(req_burst_num),
      .req_burst_size(req_burst_size),
      .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
      .rd_base(rd_base), .rd_burst_num(rd_burst_num),
      .rd_burst_size(rd_burst_size), .rd_sel(rd_sel),
      .rd_valid(rd_valid), .rd_data(rd_data),
      .rd_finish(rd_finish), .rd_burst_id(rd_burst_id),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data),
      .rsp_burst_id(rsp_burst_id), .rsp_done(rsp_done),
      .rsp_beat_cnt(rsp_beat_cnt), .busy(busy), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] base_a [NREQ];
   logic [5:0]  num_a  [NREQ];
   logic [2:0]  size_a [NREQ];

   always_comb begin
      req_base       = '0;
      req_burst_num  = '0;
      req_burst_size = '0;
      for (int k = 0; k < NREQ; k++) begin
         req_base[k*AW +: AW]     = base_a[k];
         req_burst_num[k*6 +: 6]  = num_a[k];
         req_burst_size[k*3 +: 3] = size_a[k];
      end
   end

   int n_chk;
   int n_fail;
   int m_rr;
   bit m_err;

   task automatic check(input string tag, input logic [255:0] got,
                        input logic [255:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference arbitration: scan requesters starting at the RR pointer.
   function automatic int pick(input logic [NREQ-1:0] m);
`ifdef TC_RDSCHED_FIXED_PRIO_EN
      for (int k = 0; k < NREQ; k++) if (m[k]) return k;
`else
      for (int k = 0; k < NREQ; k++)
         if (m[(m_rr + k) % NREQ]) return (m_rr + k) % NREQ;
`endif
      return -1;
   endfunction

   task automatic check_zero(input string tag);
      check({tag, "_rdy"},  req_ready, 0);
      check({tag, "_rqv"},  rd_req_valid, 0);
      check({tag, "_base"}, rd_base, 0);
      check({tag, "_num"},  rd_burst_num, 0);
      check({tag, "_size"}, rd_burst_size, 0);
      check({tag, "_sel"},  rd_sel, 0);
      check({tag, "_rspv"}, rsp_valid, 0);
      check({tag, "_data"}, rsp_data, 0);
      check({tag, "_bid"},  rsp_burst_id, 0);
      check({tag, "_done"}, rsp_done, 0);
      check({tag, "_cnt"},  rsp_beat_cnt, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_err"},  err, 0);
   endtask

   task automatic txn(input logic [NREQ-1:0] mask, input int stall,
                      input bit fin_last);
      int w;
      int n;
      logic [DW-1:0] d;
      logic [31:0] id;
      w = pick(mask);
      n = int'(num_a[w]);
      req_valid = mask;
      #1;
      check("req_ready", req_ready, 1 << w);
      check("busy_idle", busy, 0);
      tick();
      req_valid = '0;
`ifndef TC_RDSCHED_FIXED_PRIO_EN
      m_rr = (w + 1) % NREQ;
`endif
      #1;
      if (n == 0) begin
         check("z_rqv", rd_req_valid, 0);
         check("z_done", rsp_done, 1 << w);
         check("z_busy", busy, 1);
         tick();
         check("z_done_end", rsp_done, 0);
         check("z_rqv_end", rd_req_valid, 0);
         check("z_busy_end", busy, 0);
      end else begin
         for (int s = 0; s <= stall; s++) begin
            rd_req_ready = (s == stall);
            #1;
            check("iss_valid", rd_req_valid, 1);
            check("iss_sel", rd_sel, w);
            check("iss_base", rd_base, base_a[w]);
            check("iss_num", rd_burst_num, n);
            check("iss_size", rd_burst_size, size_a[w]);
            tick();
         end
         rd_req_ready = 1'b0;
         for (int b = 0; b < n; b++) begin
            if ($urandom_range(3) == 0) begin
               rd_valid = 1'b0;
               #1;
               check("gap_valid", rsp_valid, 0);
               check("gap_done", rsp_done, 0);
               tick();
            end
            for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = $urandom;
            id = $urandom;
            rd_valid    = 1'b1;
            rd_data     = d;
            rd_burst_id = id;
            rd_finish   = fin_last && (b == n - 1);
            #1;
            check("beat_valid", rsp_valid, 1 << w);
            check("beat_data", rsp_data, d);
            check("beat_id", rsp_burst_id, id);
            check("beat_done", rsp_done, rd_finish ? (1 << w) : 0);
            check("beat_sel", rd_sel, w);
            tick();
         end
         rd_valid = 1'b0;
         if (!fin_last) begin
            rd_finish = 1'b1;
            #1;
            check("fin_done", rsp_done, 1 << w);
            check("fin_valid", rsp_valid, 0);
            tick();
         end
         rd_finish = 1'b0;
         #1;
         check("beat_cnt", rsp_beat_cnt, n);
         check("end_busy", busy, 0);
         check("end_rqv", rd_req_valid, 0);
      end
      check("err_flag", err, m_err);
   endtask

   task automatic stray_beat();
      rd_valid = 1'b1;
      rd_data  = {8{32'hDEADBEEF}};
      #1;
      check("stray_rspv", rsp_valid, 0);
      tick();
      rd_valid = 1'b0;
      m_err = 1'b1;
      #1;
      check("stray_err", err, 1);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      tick();
      rst = 1'b0;
      m_rr = 0;
      m_err = 1'b0;
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      n_chk = 0;
      n_fail = 0;
      m_rr = 0;
      m_err = 1'b0;
      rst = 1'b1;
      req_valid = '0;
      rd_req_ready = 1'b0;
      rd_valid = 1'b0;
      rd_data = '0;
      rd_finish = 1'b0;
      rd_burst_id = '0;
      for (int k = 0; k < NREQ; k++) begin
         base_a[k] = '0;
         num_a[k]  = '0;
         size_a[k] = '0;
      end
      #2;
      check_zero("reset");
      tick();
      rst = 1'b0;
      #1;
      check_zero("post_reset");

      // All requesters continuously valid, 1-beat transactions.
      for (int k = 0; k < NREQ; k++) begin
         base_a[k] = 32'h100 * (k + 1);
         num_a[k]  = 6'd1;
         size_a[k] = 3'(k);
      end
      for (int r = 0; r < 6; r++) txn('1, 0, r[0]);

      base_a[1] = 32'h1000;
      num_a[1]  = 6'd4;
      size_a[1] = 3'd5;
      txn(3'b010, 0, 1'b0);

      num_a[2] = 6'd0;
      txn(3'b100, 0, 1'b0);

      num_a[0] = 6'd3;
      txn(3'b001, 5, 1'b1);
      num_a[1] = 6'd2;
      txn(3'b010, 0, 1'b1);

      // Stray beat, then reset in the middle of a data phase.
      stray_beat();
      num_a[1] = 6'd3;
      req_valid = 3'b010;
      tick();
      req_valid = '0;
      rd_req_ready = 1'b1;
      tick();
      rd_req_ready = 1'b0;
      rd_valid = 1'b1;
      #1;
      check("mid_rspv", rsp_valid, 3'b010);
      tick();
      rd_valid = 1'b0;
      rst = 1'b1;
      #1;
      check_zero("mid_rst");
      tick();
      rst = 1'b0;
      m_rr = 0;
      m_err = 1'b0;
      #1;
      check_zero("mid_rel");
      rd_finish = 1'b1;
      #1;
      check("late_done", rsp_done, 0);
      tick();
      rd_finish = 1'b0;
      #1;
      check("late_err", err, 1);
      do_reset();
      check("rst_err", err, 0);

      for (int it = 0; it < 150; it++) begin
         for (int k = 0; k < NREQ; k++) begin
            base_a[k] = $urandom;
            num_a[k]  = 6'($urandom_range(0, 6));
            size_a[k] = 3'($urandom_range(0, 7));
         end
         if ($urandom_range(19) == 0) stray_beat();
         txn(3'($urandom_range(1, 7)), $urandom_range(0, 3),
             1'($urandom_range(0, 1)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
